// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter (start, LSB-first data, optional parity, stop).
// Ports: clk_i, rst_i (async, active-high), s_tick_i, tx_start_i, din_i -> tx_busy_o, tx_done_tick_o, tx_o.
module uart_tx #(
   parameter int DataBits  = 8,
   parameter int StopTicks = 16,
   parameter bit ParityEn  = 1'b0,
   parameter bit ParityOdd = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                s_tick_i,
   input  logic                tx_start_i,
   input  logic [DataBits-1:0] din_i,
   output logic                tx_busy_o,
   output logic                tx_done_tick_o,
   output logic                tx_o
);

   localparam int NW = $clog2(DataBits);
   localparam logic [5:0] BitLast = 6'd15;
   localparam logic [5:0] StopLast = 6'(StopTicks - 1);
   localparam logic [NW-1:0] NLast = NW'(DataBits - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t state_q, state_d;
   logic [5:0] s_q, s_d;
   logic [NW-1:0] n_q, n_d;
   logic [DataBits-1:0] b_q, b_d;
   logic p_q, p_d;
   logic tx_q, tx_d;
   logic busy_q, busy_d;
   logic done;

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      p_d     = p_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tx_start_i) begin
               b_d     = din_i;
               s_d     = '0;
               p_d     = ParityOdd;
               state_d = START;
            end
         end
         START: begin
            if (s_tick_i) begin
               if (s_q == BitLast) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = DATA;
               end else begin
                  s_d = s_q + 6'd1;
               end
            end
         end
         DATA: begin
            if (s_tick_i) begin
               if (s_q == BitLast) begin
                  s_d = '0;
                  p_d = p_q ^ b_q[0];
                  b_d = b_q >> 1;
                  if (n_q == NLast) begin
                     state_d = ParityEn ? PARITY : STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 6'd1;
               end
            end
         end
         PARITY: begin
            if (s_tick_i) begin
               if (s_q == BitLast) begin
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + 6'd1;
               end
            end
         end
         STOP: begin
            if (s_tick_i) begin
               if (s_q == StopLast) begin
                  s_d     = '0;
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  s_d = s_q + 6'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is derived from the next state so tx_o is a
      // plain flop that already shows the new bit on the edge.
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = b_d[0];
         PARITY:  tx_d = p_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         p_q     <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         p_q     <= p_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   // Done is Mealy: it coincides with the final stop tick.
   assign tx_done_tick_o = done;
   assign tx_busy_o      = busy_q;
   assign tx_o           = tx_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that turns a parallel word into an asynchronous frame: start bit, LSB-first data, optional parity, and stop bit(s). It sits directly downstream of the baud-rate tick generator, consuming its 16x-oversampling tick on `s_tick_i` to time each bit. Upstream logic issues a single-cycle start request with the data word. The transmitter reports completion with a one-cycle done pulse and drives the registered serial line `tx_o`.

## Interface
- DataBits, 8, data bits per frame; legal range 5–9.
- StopTicks, 16, stop-bit length in oversampling ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- ParityEn, 0, 1 inserts a parity bit after the data bits.
- ParityOdd, 0, parity sense when ParityEn = 1; 0 = even, 1 = odd.
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- s_tick_i  input  1  oversampling tick, 16 per bit period, one clk wide.
- tx_start_i  input  1  start request; sampled only in IDLE.
- din_i  input  DataBits  word to send; captured on acceptance.
- tx_busy_o  output  1  high whenever the FSM is not in IDLE.
- tx_done_tick_o  output  1  one-cycle pulse at the end of the stop bit.
- tx_o  output  1  serial line; idles high.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Internal registers:
  - tick counter `s`, wide enough for StopTicks-1 (6 bits).
  - bit counter `n`, ceil(log2(DataBits)) bits.
  - shift register `b`, DataBits wide.
  - parity accumulator `p`, 1 bit.
  - `tx_o` is a flop (`tx_reg`), never combinational.
- Reset values: state IDLE, `s` = 0, `n` = 0, `b` = 0, `p` = 0, `tx_o` = 1, `tx_busy_o` = 0, `tx_done_tick_o` = 0.
- IDLE:
  - `tx_reg` = 1.
  - On `tx_start_i` = 1: `b` <= din_i, `s` <= 0, `p` <= ParityOdd, go to START.
  - `tx_start_i` is not gated by `s_tick_i`.
- START:
  - `tx_reg` = 0.
  - On each `s_tick_i`: if `s` == 15, then `s` <= 0, `n` <= 0, go to DATA; otherwise `s` <= `s` + 1.
- DATA:
  - `tx_reg` = b[0].
  - On each `s_tick_i` with `s` == 15: `s` <= 0, `p` <= `p` ^ b[0], `b` <= `b` >> 1.
  - Then, if `n` == DataBits-1, go to PARITY when ParityEn = 1, otherwise STOP. Else `n` <= `n` + 1.
  - On other ticks: `s` <= `s` + 1.
- PARITY (only reachable when ParityEn = 1):
  - `tx_reg` = `p`.
  - On a tick with `s` == 15: `s` <= 0, go to STOP.
- STOP:
  - `tx_reg` = 1.
  - On a tick with `s` == StopTicks-1: `tx_done_tick_o` = 1 (Mealy, same cycle), go to IDLE.
- `tx_start_i` outside IDLE is ignored and not queued.
- `din_i` may change freely after acceptance.
- Changes to `s_tick_i` spacing mid-frame are not supported.

## Timing
- `tx_o` goes low on the first clk edge after `tx_start_i` is sampled high in IDLE. `tx_busy_o` rises on the same edge.
- The first bit is 15–16 tick periods long. Start-bit length = 15 full tick periods plus the partial period up to the first tick.
- Each data and parity bit is exactly 16 tick periods.
- The stop bit is StopTicks tick periods. The last period ends on the edge where `tx_done_tick_o` is high.
- `tx_done_tick_o` is high for exactly one clk cycle, coincident with the final `s_tick_i`. On the following edge: state = IDLE, `tx_busy_o` = 0.
- Back-to-back frames:
  - `tx_start_i` held high through `tx_done_tick_o` is accepted on the first IDLE cycle.
  - Minimum inter-frame gap is one clk cycle of idle-high line.
- `rst_i` mid-frame: `tx_o` = 1 and state = IDLE immediately, asynchronously. No done pulse. The partial frame is abandoned.
- Frame length in ticks = 16 × (1 + DataBits + ParityEn) + StopTicks.

## Test plan
- Defaults, `s_tick_i` tied high, `din_i` = 0xA5, one-cycle `tx_start_i`:
  - `tx_o` = 0 for 16 cycles.
  - Then bits 1,0,1,0,0,1,0,1, 16 cycles each.
  - Then 1 for 16 cycles.
  - `tx_done_tick_o` pulses once, at cycle 160 after the start bit begins.
- Ticks every 325 clks (19200 baud at 100 MHz), `din_i` = 0x55: the monitor samples mid-bit and recovers 0x55. Each bit lasts 16 × 325 = 5200 clk ± 325 on the start bit.
- ParityEn = 1, ParityOdd = 0, `din_i` = 0x07 → parity bit 1. With ParityOdd = 1 → parity bit 0. The frame is 176 ticks.
- StopTicks = 32, back-to-back starts with `tx_start_i` held high:
  - Stop bit = 32 ticks, then exactly one idle clk.
  - `tx_o` stays high across the gap.
  - The next start bit begins.
  - `tx_start_i` pulses during the frame cause no glitch.
- Assert `rst_i` during DATA bit 3 → `tx_o` = 1, `tx_busy_o` = 0 immediately, no `tx_done_tick_o`. After release, a new frame with 0x3C transmits correctly.
- DataBits = 7, `din_i` = 0x7F → 7 ones on the line, frame = 144 ticks. `din_i` changed after acceptance does not alter the transmitted bits.
